// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// pipe_pkg
// Shared widths, ID/EX control-bundle layout and bubble values for stage regs.
// Revision: 1.0
// ============================================================================
package pipe_pkg;

  typedef enum logic [1:0] {
    BND_IFID  = 2'd0,
    BND_IDEX  = 2'd1,
    BND_EXMEM = 2'd2,
    BND_MEMWB = 2'd3
  } boundary_e;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_CTRL_W = 12;
  localparam int DEFAULT_CNT_W  = 16;

  localparam int IFID_CTRL_W  = 1;
  localparam int IFID_DATA_W  = 64;
  localparam int IDEX_CTRL_W  = 12;
  localparam int IDEX_DATA_W  = 32;
  localparam int EXMEM_CTRL_W = 4;
  localparam int EXMEM_DATA_W = 69;
  localparam int MEMWB_CTRL_W = 2;
  localparam int MEMWB_DATA_W = 69;

  // ID/EX control field offsets; bit 11 is spare
  localparam int IDEX_ALUOP_LSB = 0;
  localparam int IDEX_REGWRITE  = 4;
  localparam int IDEX_MEMTOREG  = 5;
  localparam int IDEX_MEM_WEN   = 6;
  localparam int IDEX_MEM_REN   = 7;
  localparam int IDEX_REGDST    = 8;
  localparam int IDEX_ALUSRC    = 9;
  localparam int IDEX_SHIFT     = 10;

  localparam logic [IFID_CTRL_W-1:0]  IFID_BUBBLE  = '0;
  localparam logic [IDEX_CTRL_W-1:0]  IDEX_BUBBLE  = '0;
  localparam logic [EXMEM_CTRL_W-1:0] EXMEM_BUBBLE = '0;
  localparam logic [MEMWB_CTRL_W-1:0] MEMWB_BUBBLE = '0;

  typedef struct packed {
    logic       shift;
    logic       alusrc;
    logic       regdst;
    logic       mem_ren;
    logic       mem_wen;
    logic       memtoreg;
    logic       regwrite;
    logic [3:0] aluop;
  } idex_ctrl_t;

  function automatic logic [IDEX_CTRL_W-1:0] idex_pack(input idex_ctrl_t c);
    return {1'b0, c};
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_stage_reg_if.sv
`default_nettype none
// ============================================================================
// pipe_stage_reg_if
// Valid/ready beat carrying a control and a data bundle.
// Revision: 1.0
// ============================================================================
interface pipe_stage_reg_if #(
  parameter int CTRL_W = 12,
  parameter int DATA_W = 32
) ();
  logic              valid;
  logic              ready;
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] data;

  modport master (output valid, output ctrl, output data, input ready);
  modport slave  (input valid, input ctrl, input data, output ready);
endinterface
`default_nettype wire

// File: rtl/pipe_entry_reg.sv
`default_nettype none
// ============================================================================
// pipe_entry_reg
// One valid + ctrl + data register; clear wins over load.
// Revision: 1.0
// ============================================================================
module pipe_entry_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = DEFAULT_CTRL_W,
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_i,
  input  logic              clr_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [DATA_W-1:0] data_q;

  // Clearing only drops the valid bit so dn_data keeps its last value
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else if (clr_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      ctrl_q  <= ctrl_i;
      data_q  <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign ctrl_o  = ctrl_q;
  assign data_o  = data_q;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// pipe_stage_reg
// Handshaked pipeline register with optional skid entry, flush and stall count.
// Revision: 1.0
// ============================================================================
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W      = DEFAULT_DATA_W,
  parameter int                CTRL_W      = DEFAULT_CTRL_W,
  parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0,
  parameter int                SKID        = 1,
  parameter int                CNT_W       = DEFAULT_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  pipe_stage_reg_if.slave  up,
  pipe_stage_reg_if.master dn,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              main_valid;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic              main_load;
  logic              main_clr;
  logic [CTRL_W-1:0] main_ctrl_in;
  logic [DATA_W-1:0] main_data_in;

  logic              skid_valid;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;

  logic              up_ready;
  logic              accept;
  logic              release_beat;

  logic [CNT_W-1:0]  stall_cnt_q;
  logic [CNT_W-1:0]  stall_cnt_d;

  assign accept       = up.valid & up_ready;
  assign release_beat = main_valid & dn.ready;

  // When the skid holds a beat it is older than anything upstream
  assign main_ctrl_in = skid_valid ? skid_ctrl : up.ctrl;
  assign main_data_in = skid_valid ? skid_data : up.data;

  generate
    if (SKID != 0) begin : g_skid
      logic skid_load;
      logic skid_clr;

      assign up_ready  = !skid_valid;
      assign main_load = (accept & (!main_valid | (release_beat & !skid_valid)))
                       | (release_beat & skid_valid);
      assign main_clr  = flush | (release_beat & !skid_valid & !accept);
      assign skid_load = accept & main_valid & !release_beat;
      assign skid_clr  = flush | (release_beat & skid_valid);

      pipe_entry_reg #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
      ) u_skid (
        .clock   (clock),
        .reset   (reset),
        .load_i  (skid_load),
        .clr_i   (skid_clr),
        .ctrl_i  (up.ctrl),
        .data_i  (up.data),
        .valid_o (skid_valid),
        .ctrl_o  (skid_ctrl),
        .data_o  (skid_data)
      );
    end else begin : g_noskid
      assign up_ready   = !main_valid | dn.ready;
      assign main_load  = accept;
      assign main_clr   = flush | (release_beat & !accept);
      assign skid_valid = 1'b0;
      assign skid_ctrl  = '0;
      assign skid_data  = '0;
    end
  endgenerate

  pipe_entry_reg #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W)
  ) u_main (
    .clock   (clock),
    .reset   (reset),
    .load_i  (main_load),
    .clr_i   (main_clr),
    .ctrl_i  (main_ctrl_in),
    .data_i  (main_data_in),
    .valid_o (main_valid),
    .ctrl_o  (main_ctrl),
    .data_o  (main_data)
  );

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (main_valid && !dn.ready && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign up.ready  = up_ready;
  assign dn.valid  = main_valid;
  assign dn.ctrl   = main_valid ? main_ctrl : BUBBLE_CTRL;
  assign dn.data   = main_data;
  assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};
  assign stall_cnt = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// tb_pipe_stage_reg
// Directed checks of a skid (CNT_W=4) and a non-skid instance.
// Revision: 1.0
// ============================================================================
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int DW = 32;
  localparam int CW = 12;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic flush_s = 1'b0;
  logic flush_n = 1'b0;
  logic [1:0]  occ_s;
  logic [1:0]  occ_n;
  logic [3:0]  cnt_s;
  logic [15:0] cnt_n;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) up_s ();
  pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) dn_s ();
  pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) up_n ();
  pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) dn_n ();

  pipe_stage_reg #(
    .DATA_W(DW), .CTRL_W(CW), .BUBBLE_CTRL(IDEX_BUBBLE), .SKID(1), .CNT_W(4)
  ) u_dut_skid (
    .clock(clock), .reset(reset), .flush(flush_s),
    .up(up_s.slave), .dn(dn_s.master), .occupancy(occ_s), .stall_cnt(cnt_s)
  );

  pipe_stage_reg #(
    .DATA_W(DW), .CTRL_W(CW), .BUBBLE_CTRL(IDEX_BUBBLE), .SKID(0), .CNT_W(16)
  ) u_dut_noskid (
    .clock(clock), .reset(reset), .flush(flush_n),
    .up(up_n.slave), .dn(dn_n.master), .occupancy(occ_n), .stall_cnt(cnt_n)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_s(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d);
    up_s.valid = v;
    up_s.ctrl  = c;
    up_s.data  = d;
  endtask

  task automatic drive_n(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d);
    up_n.valid = v;
    up_n.ctrl  = c;
    up_n.data  = d;
  endtask

  initial begin
    idex_ctrl_t alu_rw;
    logic [CW-1:0] c_rw;
    alu_rw          = '0;
    alu_rw.aluop    = 4'h2;
    alu_rw.regwrite = 1'b1;
    c_rw            = idex_pack(alu_rw);

    drive_s(1'b0, '0, '0);
    drive_n(1'b0, '0, '0);
    dn_s.ready = 1'b0;
    dn_n.ready = 1'b0;

    // reset then idle
    tick();
    tick();
    reset = 1'b0;
    #1;
    check_eq("rst_dn_valid", {31'd0, dn_s.valid}, 32'd0);
    check_eq("rst_up_ready", {31'd0, up_s.ready}, 32'd1);
    check_eq("rst_dn_ctrl", {20'd0, dn_s.ctrl}, 32'd0);
    check_eq("rst_dn_data", dn_s.data, 32'd0);
    check_eq("rst_occ", {30'd0, occ_s}, 32'd0);
    check_eq("rst_cnt", {28'd0, cnt_s}, 32'd0);
    check_eq("rst_n_up_ready", {31'd0, up_n.ready}, 32'd1);

    // streaming, skid
    dn_s.ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      drive_s(1'b1, c_rw, 32'h11 * i);
      tick();
      check_eq("stream_valid", {31'd0, dn_s.valid}, 32'd1);
      check_eq("stream_data", dn_s.data, 32'h11 * i);
      check_eq("stream_ctrl", {20'd0, dn_s.ctrl}, 32'h012);
      check_eq("stream_occ", {30'd0, occ_s}, 32'd1);
      check_eq("stream_up_ready", {31'd0, up_s.ready}, 32'd1);
    end
    drive_s(1'b0, '0, '0);
    tick();
    check_eq("stream_drain_valid", {31'd0, dn_s.valid}, 32'd0);
    check_eq("stream_bubble_ctrl", {20'd0, dn_s.ctrl}, 32'd0);
    check_eq("stream_cnt", {28'd0, cnt_s}, 32'd0);

    // stall and skid fill
    dn_s.ready = 1'b0;
    drive_s(1'b1, 12'h0A1, 32'hA);
    tick();
    check_eq("stall_a_occ", {30'd0, occ_s}, 32'd1);
    check_eq("stall_a_cnt", {28'd0, cnt_s}, 32'd0);
    drive_s(1'b1, 12'h0B2, 32'hB);
    tick();
    check_eq("skid_occ", {30'd0, occ_s}, 32'd2);
    check_eq("skid_up_ready", {31'd0, up_s.ready}, 32'd0);
    check_eq("skid_data_a", dn_s.data, 32'hA);
    check_eq("skid_cnt1", {28'd0, cnt_s}, 32'd1);
    drive_s(1'b1, 12'h0DD, 32'hD);
    tick();
    check_eq("hold_data_a", dn_s.data, 32'hA);
    check_eq("hold_ctrl_a", {20'd0, dn_s.ctrl}, 32'h0A1);
    check_eq("hold_occ", {30'd0, occ_s}, 32'd2);
    check_eq("hold_cnt2", {28'd0, cnt_s}, 32'd2);
    drive_s(1'b0, '0, '0);
    dn_s.ready = 1'b1;
    tick();
    check_eq("drain_b_data", dn_s.data, 32'hB);
    check_eq("drain_b_ctrl", {20'd0, dn_s.ctrl}, 32'h0B2);
    check_eq("drain_b_occ", {30'd0, occ_s}, 32'd1);
    check_eq("drain_up_ready", {31'd0, up_s.ready}, 32'd1);
    check_eq("drain_cnt2", {28'd0, cnt_s}, 32'd2);
    tick();
    check_eq("drain_empty_valid", {31'd0, dn_s.valid}, 32'd0);
    check_eq("drain_empty_occ", {30'd0, occ_s}, 32'd0);

    // flush with two entries held
    dn_s.ready = 1'b0;
    drive_s(1'b1, 12'h111, 32'h1);
    tick();
    drive_s(1'b1, 12'h222, 32'h2);
    tick();
    check_eq("pre_flush_occ", {30'd0, occ_s}, 32'd2);
    check_eq("pre_flush_cnt", {28'd0, cnt_s}, 32'd3);
    drive_s(1'b1, 12'hCCC, 32'hC);
    flush_s = 1'b1;
    tick();
    flush_s = 1'b0;
    drive_s(1'b0, '0, '0);
    check_eq("flush_valid", {31'd0, dn_s.valid}, 32'd0);
    check_eq("flush_ctrl", {20'd0, dn_s.ctrl}, 32'd0);
    check_eq("flush_occ", {30'd0, occ_s}, 32'd0);
    check_eq("flush_data_kept", dn_s.data, 32'h1);
    check_eq("flush_cnt", {28'd0, cnt_s}, 32'd4);
    tick();
    check_eq("flush_no_c", {31'd0, dn_s.valid}, 32'd0);

    // flush drops the beat accepted the same cycle
    dn_s.ready = 1'b1;
    drive_s(1'b1, 12'h0EE, 32'hE);
    flush_s = 1'b1;
    tick();
    flush_s = 1'b0;
    drive_s(1'b0, '0, '0);
    check_eq("flush_acc_valid", {31'd0, dn_s.valid}, 32'd0);
    check_eq("flush_acc_occ", {30'd0, occ_s}, 32'd0);

    // saturation of the 4-bit counter, then reset mid-stall
    dn_s.ready = 1'b0;
    drive_s(1'b1, 12'h03F, 32'h3F);
    tick();
    drive_s(1'b0, '0, '0);
    repeat (20) tick();
    check_eq("sat_cnt", {28'd0, cnt_s}, 32'd15);
    tick();
    check_eq("sat_hold", {28'd0, cnt_s}, 32'd15);
    check_eq("sat_data_stable", dn_s.data, 32'h3F);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("rst2_cnt", {28'd0, cnt_s}, 32'd0);
    check_eq("rst2_valid", {31'd0, dn_s.valid}, 32'd0);
    check_eq("rst2_occ", {30'd0, occ_s}, 32'd0);
    check_eq("rst2_data", dn_s.data, 32'd0);
    check_eq("rst2_up_ready", {31'd0, up_s.ready}, 32'd1);

    // no-skid: combinational ready and full throughput
    dn_n.ready = 1'b0;
    drive_n(1'b1, 12'h055, 32'h5);
    #1;
    check_eq("n_empty_ready", {31'd0, up_n.ready}, 32'd1);
    tick();
    check_eq("n_held_valid", {31'd0, dn_n.valid}, 32'd1);
    check_eq("n_held_data", dn_n.data, 32'h5);
    drive_n(1'b1, 12'h066, 32'h6);
    #1;
    check_eq("n_full_stall_ready", {31'd0, up_n.ready}, 32'd0);
    dn_n.ready = 1'b1;
    #1;
    check_eq("n_full_pass_ready", {31'd0, up_n.ready}, 32'd1);
    tick();
    check_eq("n_thru_data", dn_n.data, 32'h6);
    check_eq("n_thru_ctrl", {20'd0, dn_n.ctrl}, 32'h066);
    check_eq("n_thru_occ", {30'd0, occ_n}, 32'd1);
    check_eq("n_thru_cnt", {16'd0, cnt_n}, 32'd0);
    drive_n(1'b0, '0, '0);
    tick();
    check_eq("n_drain_valid", {31'd0, dn_n.valid}, 32'd0);
    check_eq("n_drain_ctrl", {20'd0, dn_n.ctrl}, 32'd0);
    drive_n(1'b1, 12'h077, 32'h7);
    flush_n = 1'b1;
    tick();
    flush_n = 1'b0;
    drive_n(1'b0, '0, '0);
    check_eq("n_flush_valid", {31'd0, dn_n.valid}, 32'd0);
    check_eq("n_flush_occ", {30'd0, occ_n}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
